// File: rtl/tm_input_sequencer.sv
// rtl/tm_input_sequencer.sv - program loader and single-step/auto-run sequencer for a Turing machine core
module tm_input_sequencer #(
    parameter int DW      = 4,
    parameter int NEXT_HI = 2,
    parameter int NEXT_LO = 2,
    parameter int DEB     = 4
) (
    input  logic          clock,
    input  logic          Reset_n,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    input  logic          step_btn,
    input  logic          auto_run,
    input  logic [7:0]    auto_period,
    input  logic [1:0]    tm_direction,
    output logic [DW-1:0] input_data,
    output logic          Next,
    output logic          Done,
    output logic [1:0]    phase,
    output logic [15:0]   step_count
);

    typedef enum logic [2:0] {
        LOAD_WAIT, LOAD_HI, LOAD_LO, DONE_PULSE, RUN_WAIT, RUN_HI, RUN_LO, HALTED
    } state_t;

    localparam int         DCW     = (DEB > 1) ? $clog2(DEB) : 1;
    localparam logic [DCW-1:0] DEB_MAX = DCW'(DEB - 1);
    localparam logic [3:0] HI_MAX  = 4'(NEXT_HI - 1);
    localparam logic [3:0] LO_MAX  = 4'(NEXT_LO - 1);

    logic rst_meta_q, rst_n_q;
    logic btn_s1_q, btn_s2_q;
    logic deb_q, deb_d, deb_prev_q;
    logic [DCW-1:0] deb_cnt_q, deb_cnt_d;
    logic step_req, auto_fire;

    state_t         state_q, state_d;
    logic           next_q, next_d, done_q, done_d, last_q, last_d;
    logic [3:0]     pcnt_q, pcnt_d;
    logic [7:0]     acnt_q, acnt_d;
    logic [DW-1:0]  data_q, data_d;
    logic [15:0]    steps_q, steps_d;

    logic unused_dir;
    assign unused_dir = tm_direction[0];

    // Assertion is immediate; release is retimed so no flop sees a runt reset edge.
    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            rst_meta_q <= 1'b0;
            rst_n_q    <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_n_q    <= rst_meta_q;
        end
    end

    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (btn_s2_q != deb_q) begin
            if (deb_cnt_q == DEB_MAX) deb_d = btn_s2_q;
            else deb_cnt_d = deb_cnt_q + DCW'(1);
        end
    end

    always_ff @(posedge clock or negedge rst_n_q) begin
        if (!rst_n_q) begin
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            deb_cnt_q  <= '0;
        end else begin
            btn_s1_q   <= step_btn;
            btn_s2_q   <= btn_s1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            deb_cnt_q  <= deb_cnt_d;
        end
    end

    assign step_req  = deb_q & ~deb_prev_q;
    assign auto_fire = auto_run && (acnt_q == auto_period);
    assign in_ready  = (state_q == LOAD_WAIT) && rst_n_q;

    always_comb begin
        state_d = state_q;
        next_d  = 1'b0;
        done_d  = 1'b0;
        pcnt_d  = pcnt_q;
        data_d  = data_q;
        last_d  = last_q;
        acnt_d  = 8'd0;
        steps_d = steps_q;
        case (state_q)
            LOAD_WAIT: begin
                if (in_valid && in_ready) begin
                    data_d  = in_data;
                    last_d  = in_last;
                    state_d = LOAD_HI;
                    next_d  = 1'b1;
                    pcnt_d  = 4'd0;
                end
            end
            LOAD_HI, RUN_HI: begin
                if (pcnt_q == HI_MAX) begin
                    state_d = (state_q == LOAD_HI) ? LOAD_LO : RUN_LO;
                    pcnt_d  = 4'd0;
                end else begin
                    pcnt_d = pcnt_q + 4'd1;
                    next_d = 1'b1;
                end
            end
            LOAD_LO: begin
                if (pcnt_q == LO_MAX) begin
                    pcnt_d = 4'd0;
                    if (last_q) begin
                        state_d = DONE_PULSE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LOAD_WAIT;
                    end
                end else begin
                    pcnt_d = pcnt_q + 4'd1;
                end
            end
            DONE_PULSE: state_d = RUN_WAIT;
            RUN_WAIT: begin
                // Halt wins over any pending step; button and auto steps merge into one.
                if (tm_direction[1]) begin
                    state_d = HALTED;
                end else if (step_req || auto_fire) begin
                    state_d = RUN_HI;
                    next_d  = 1'b1;
                    pcnt_d  = 4'd0;
                    if (steps_q != 16'hFFFF) steps_d = steps_q + 16'd1;
                end else if (auto_run) begin
                    acnt_d = acnt_q + 8'd1;
                end
            end
            RUN_LO: begin
                if (pcnt_q == LO_MAX) begin
                    pcnt_d  = 4'd0;
                    state_d = tm_direction[1] ? HALTED : RUN_WAIT;
                end else begin
                    pcnt_d = pcnt_q + 4'd1;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = LOAD_WAIT;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n_q) begin
        if (!rst_n_q) begin
            state_q <= LOAD_WAIT;
            next_q  <= 1'b0;
            done_q  <= 1'b0;
            pcnt_q  <= 4'd0;
            acnt_q  <= 8'd0;
            data_q  <= '0;
            last_q  <= 1'b0;
            steps_q <= 16'd0;
        end else begin
            state_q <= state_d;
            next_q  <= next_d;
            done_q  <= done_d;
            pcnt_q  <= pcnt_d;
            acnt_q  <= acnt_d;
            data_q  <= data_d;
            last_q  <= last_d;
            steps_q <= steps_d;
        end
    end

    always_comb begin
        case (state_q)
            RUN_WAIT, RUN_HI, RUN_LO: phase = 2'd1;
            HALTED:                   phase = 2'd2;
            default:                  phase = 2'd0;
        endcase
    end

    assign input_data = data_q;
    assign Next       = next_q;
    assign Done       = done_q;
    assign step_count = steps_q;

endmodule

// File: tb/tb_tm_input_sequencer.sv
// tb/tb_tm_input_sequencer.sv - self-checking bench for tm_input_sequencer
module tb_tm_input_sequencer;
    localparam int DW = 4, NEXT_HI = 2, NEXT_LO = 2, DEB = 4;

    logic          clock, Reset_n;
    logic [DW-1:0] in_data;
    logic          in_valid, in_last, in_ready, step_btn, auto_run;
    logic [7:0]    auto_period;
    logic [1:0]    tm_direction;
    logic [DW-1:0] input_data;
    logic          Next, Done;
    logic [1:0]    phase;
    logic [15:0]   step_count;

    tm_input_sequencer #(.DW(DW), .NEXT_HI(NEXT_HI), .NEXT_LO(NEXT_LO), .DEB(DEB)) dut (
        .clock(clock), .Reset_n(Reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .step_btn(step_btn), .auto_run(auto_run),
        .auto_period(auto_period), .tm_direction(tm_direction), .input_data(input_data),
        .Next(Next), .Done(Done), .phase(phase), .step_count(step_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0, failures = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    // Reference: countdown timers for the pulse phases, a window rule for the debouncer.
    int            m_rel = 0, m_hi = 0, m_lo = 0;
    bit            m_done = 0, m_run = 0, m_halt = 0, m_last = 0, m_deb = 0, m_debp = 0;
    logic [DW-1:0] m_data = '0;
    logic [15:0]   m_steps = '0;
    logic [7:0]    m_acnt = '0;
    bit            samp[$];

    function automatic void m_reset();
        m_hi = 0; m_lo = 0; m_done = 0; m_run = 0; m_halt = 0; m_last = 0;
        m_deb = 0; m_debp = 0; m_data = '0; m_steps = '0; m_acnt = '0;
        samp.delete();
        for (int i = 0; i < DEB + 2; i++) samp.push_back(1'b0);
    endfunction

    always @(posedge clock) begin : model
        bit req, fire, all_eq, v;
        if (!Reset_n) begin
            m_reset(); m_rel = 0;
        end else if (m_rel < 2) begin
            m_reset(); m_rel++;
        end else begin
            req    = m_deb && !m_debp;
            m_debp = m_deb;
            v      = samp[samp.size()-2];
            all_eq = 1;
            for (int i = 0; i < DEB; i++) if (samp[samp.size()-2-i] != v) all_eq = 0;
            if (all_eq) m_deb = v;
            samp.push_back(step_btn);
            void'(samp.pop_front());
            if (m_halt) begin
            end else if (m_hi > 0) begin
                m_hi--;
                if (m_hi == 0) m_lo = NEXT_LO;
            end else if (m_lo > 0) begin
                m_lo--;
                if (m_lo == 0) begin
                    if (!m_run) m_done = m_last;
                    else if (tm_direction[1]) m_halt = 1;
                end
            end else if (m_done) begin
                m_done = 0; m_run = 1; m_acnt = 0;
            end else if (!m_run) begin
                if (in_valid) begin
                    m_data = in_data; m_last = in_last; m_hi = NEXT_HI;
                end
            end else begin
                fire = auto_run && (m_acnt == auto_period);
                if (tm_direction[1]) m_halt = 1;
                else if (req || fire) begin
                    m_hi = NEXT_HI; m_acnt = 0;
                    if (m_steps != 16'hFFFF) m_steps++;
                end else m_acnt = auto_run ? m_acnt + 8'd1 : 8'd0;
            end
        end
    end

    int   cyc_n = 0, nrise = 0, done_cnt = 0, hi_run = 0;
    logic prev_next = 0;
    int   rise_cyc[$], hi_lens[$];
    logic [DW-1:0] rise_data[$];

    always @(negedge clock) begin : compare
        bit rst_now;
        rst_now = !Reset_n;
        chk("Next",       Next,       rst_now ? 0 : (m_hi > 0));
        chk("Done",       Done,       rst_now ? 0 : m_done);
        chk("in_ready",   in_ready,   rst_now ? 0 : (m_rel >= 2 && !m_run && !m_halt && m_hi == 0 && m_lo == 0 && !m_done));
        chk("phase",      phase,      rst_now ? 0 : (m_halt ? 2 : (m_run ? 1 : 0)));
        chk("step_count", step_count, rst_now ? 0 : m_steps);
        chk("input_data", input_data, rst_now ? 0 : m_data);
        cyc_n++;
        if (Next && !prev_next) begin
            nrise++; rise_cyc.push_back(cyc_n); rise_data.push_back(input_data);
        end
        if (Next) hi_run++;
        else if (prev_next) begin hi_lens.push_back(hi_run); hi_run = 0; end
        if (Done) done_cnt++;
        prev_next = Next;
    end

    task automatic cyc(int n);
        repeat (n) begin @(posedge clock); #2; end
    endtask

    task automatic do_reset(int n);
        Reset_n = 0; in_valid = 0; in_last = 0; in_data = '0; step_btn = 0;
        auto_run = 0; auto_period = '0; tm_direction = '0;
        cyc(n);
        Reset_n = 1;
        cyc(3);
    endtask

    task automatic send_word(logic [DW-1:0] d, bit last);
        bit ok = 0;
        in_data = d; in_last = last; in_valid = 1;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clock);
            if (in_ready) ok = 1;
            @(posedge clock); #2;
        end
        chk("xfer_timeout", ok, 1);
    endtask

    task automatic wait_next(logic v, string nm);
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clock);
            if (Next === v) seen = 1;
        end
        chk({"timeout_", nm}, seen, 1);
    endtask

    task automatic wait_phase(logic [1:0] p);
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clock);
            if (phase === p) seen = 1;
        end
        chk("timeout_phase", seen, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1);
    end

    int base;
    initial begin
        Reset_n = 0; in_valid = 0; in_last = 0; in_data = '0; step_btn = 0;
        auto_run = 0; auto_period = '0; tm_direction = '0;
        cyc(3);
        chk("rst_next", Next, 0);
        chk("rst_done", Done, 0);
        chk("rst_phase", phase, 0);
        chk("rst_steps", step_count, 0);
        chk("rst_data", input_data, 0);
        Reset_n = 1;
        cyc(3);
        chk("rel_ready", in_ready, 1);

        // Load 5, A, 3 with the button pressed during loading.
        rise_cyc.delete(); rise_data.delete(); hi_lens.delete();
        base = nrise;
        step_btn = 1;
        send_word(4'h5, 0);
        send_word(4'hA, 0);
        step_btn = 0;
        send_word(4'h3, 1);
        in_valid = 0; in_last = 0;
        wait_phase(2'd1);
        chk("load_rises", nrise - base, 3);
        chk("load_done", done_cnt, 1);
        chk("load_steps", step_count, 0);
        chk("load_nlens", hi_lens.size(), 3);
        if (rise_data.size() >= 3 && hi_lens.size() >= 3) begin
            chk("load_w0", rise_data[0], 4'h5);
            chk("load_w1", rise_data[1], 4'hA);
            chk("load_w2", rise_data[2], 4'h3);
            chk("load_len0", hi_lens[0], 2);
            chk("load_len2", hi_lens[2], 2);
            chk("load_gap01", rise_cyc[1] - rise_cyc[0], 5);
            chk("load_gap12", rise_cyc[2] - rise_cyc[1], 5);
        end
        cyc(10);

        // Bouncy press gives one step.
        base = nrise;
        step_btn = 1; cyc(1); step_btn = 0; cyc(1); step_btn = 1; cyc(11);
        step_btn = 0; cyc(12);
        chk("bounce_rises", nrise - base, 1);
        chk("bounce_steps", step_count, 1);

        // Auto run with period 3.
        rise_cyc.delete();
        base = nrise;
        auto_period = 8'd3; auto_run = 1;
        cyc(40);
        auto_run = 0;
        cyc(8);
        chk("auto_rises", nrise - base, 5);
        chk("auto_steps", step_count, 6);
        for (int i = 1; i < rise_cyc.size(); i++) chk("auto_gap", rise_cyc[i] - rise_cyc[i-1], 8);

        // Halt raised during RUN_LO.
        step_btn = 1;
        wait_next(1, "halt_hi");
        wait_next(0, "halt_lo");
        tm_direction = 2'b10; step_btn = 0;
        cyc(5);
        chk("halt_phase", phase, 2);
        base = nrise;
        tm_direction = 2'b00;
        repeat (2) begin step_btn = 1; cyc(8); step_btn = 0; cyc(8); end
        chk("halt_no_next", nrise - base, 0);
        chk("halt_steps", step_count, 7);
        chk("halt_phase2", phase, 2);

        // Reset in the middle of a load pulse.
        do_reset(2);
        in_data = 4'h9; in_last = 1; in_valid = 1;
        wait_next(1, "rst_hi");
        cyc(1);
        Reset_n = 0; in_valid = 0;
        #1;
        chk("midrst_next", Next, 0);
        chk("midrst_phase", phase, 0);
        cyc(1);
        Reset_n = 1;
        cyc(3);
        chk("midrst_ready", in_ready, 1);
        chk("midrst_steps", step_count, 0);

        // Randomised sessions against the reference.
        for (int r = 0; r < 10; r++) begin
            int nw;
            do_reset(1 + $urandom_range(0, 2));
            nw = $urandom_range(1, 4);
            for (int w = 0; w < nw; w++) begin
                in_valid = 0;
                repeat ($urandom_range(0, 2)) begin
                    step_btn = $urandom_range(0, 1); cyc(1);
                end
                send_word(DW'($urandom), w == nw - 1);
            end
            in_valid = 0; in_last = 0;
            for (int c = 0; c < 150; c++) begin
                if ($urandom_range(0, 5) == 0) step_btn = ~step_btn;
                if ($urandom_range(0, 19) == 0) auto_run = $urandom_range(0, 1);
                if ($urandom_range(0, 19) == 0) auto_period = 8'($urandom_range(0, 6));
                tm_direction = {($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1))};
                in_valid = $urandom_range(0, 1);
                in_data = DW'($urandom);
                cyc(1);
            end
        end

        in_valid = 0;
        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
